// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, fetch FSM states and the IF/ID record.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FETCH, HOLD, HALTED} fetch_state_t;
  localparam word_t PC_STEP = 32'd4;
  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;
  localparam ifid_t IFID_BUBBLE = '0;
endpackage

// File: rtl/if_id_if.sv
// if_id_if: IF/ID pipeline register bundle; fetch drives it, decode reads it.
interface if_id_if;
  import cpu_types_pkg::*;
  logic  valid;
  word_t instr;
  word_t pc;
  word_t npc;
  modport ifid (output valid, instr, pc, npc);
  modport id (input valid, instr, pc, npc);
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: PC owner, I-cache request handshake and IF/ID register with a one-entry skid buffer.
module if_id_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h00000000
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  iREN,
  output word_t iaddr,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  idStall,
  input  logic  flush,
  input  word_t redirect_addr,
  input  logic  halt,
  output word_t pc,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc
);
  fetch_state_t state, stateNext;
  word_t pcQ, pcNext, skidInstr, skidInstrNext, skidPc, skidPcNext;
  ifid_t ifidQ, ifidNext;
  if_id_if ifidBus ();

  always_comb begin
    stateNext     = state;
    pcNext        = pcQ;
    ifidNext      = ifidQ;
    skidInstrNext = skidInstr;
    skidPcNext    = skidPc;
    if (state != HALTED) begin
      if (halt) begin
        stateNext = HALTED;
        ifidNext  = IFID_BUBBLE;
      end else if (flush) begin
        stateNext = FETCH;
        pcNext    = redirect_addr;
        ifidNext  = IFID_BUBBLE;
      end else if (state == HOLD) begin
        if (!idStall) begin
          stateNext = FETCH;
          ifidNext  = '{1'b1, skidInstr, skidPc, skidPc + PC_STEP};
        end
      end else if (ihit) begin
        pcNext = pcQ + PC_STEP;
        if (idStall) begin
          stateNext     = HOLD;
          skidInstrNext = imemload;
          skidPcNext    = pcQ;
        end else begin
          ifidNext = '{1'b1, imemload, pcQ, pcQ + PC_STEP};
        end
      end else if (!idStall) begin
        ifidNext = IFID_BUBBLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FETCH;
      pcQ       <= PC_INIT;
      ifidQ     <= IFID_BUBBLE;
      skidInstr <= '0;
      skidPc    <= '0;
    end else begin
      state     <= stateNext;
      pcQ       <= pcNext;
      ifidQ     <= ifidNext;
      skidInstr <= skidInstrNext;
      skidPc    <= skidPcNext;
    end
  end

  // request side never looks at ihit, so the cache sees a glitch-free iREN
  assign iREN  = state == FETCH;
  assign iaddr = pcQ;
  assign pc    = pcQ;

  assign ifidBus.valid = ifidQ.valid;
  assign ifidBus.instr = ifidQ.instr;
  assign ifidBus.pc    = ifidQ.pc;
  assign ifidBus.npc   = ifidQ.npc;
  assign ifid_valid    = ifidBus.valid;
  assign ifid_instr    = ifidBus.instr;
  assign ifid_pc       = ifidBus.pc;
  assign ifid_npc      = ifidBus.npc;
endmodule
